// File: rtl/sr_cmd_driver.sv
// sr_cmd_driver: turns raw, bouncy set/clear request lines into clean,
// fixed-width S and R pulses for a downstream SR flip-flop stage. The
// forbidden S=R=1 combination is never produced, a hold-off gap separates
// commands, and the last commanded Q value is tracked.
module sr_cmd_driver #(
  parameter int DB_CYCLES    = 4,
  parameter int PULSE_LEN    = 2,
  parameter int HOLDOFF      = 2,
  parameter int CLR_PRIORITY = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       set_req,
  input  logic       clr_req,
  output logic       S,
  output logic       R,
  output logic       busy,
  output logic       q_expect,
  output logic [7:0] conflict_cnt
);

  localparam int PHASE_MAX = (PULSE_LEN > HOLDOFF) ? PULSE_LEN : HOLDOFF;
  localparam int PW        = $clog2(PHASE_MAX) + 1;
  localparam logic [PW-1:0] PULSE_LAST = PW'(PULSE_LEN - 1);
  // GAP is unreachable when HOLDOFF is zero; the clamp keeps the constant legal.
  localparam logic [PW-1:0] GAP_LAST   = PW'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);
  localparam logic [7:0]    DB_LAST    = 8'(DB_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DRIVE_S = 2'd1,
    DRIVE_R = 2'd2,
    GAP     = 2'd3
  } state_t;

  // Bit 0 carries the set request path, bit 1 the clear request path.
  logic [1:0]      sync1_q, sync1_d;
  logic [1:0]      sync2_q, sync2_d;
  logic [1:0]      db_q, db_d;
  logic [1:0]      db_prev_q, db_prev_d;
  logic [1:0][7:0] db_cnt_q, db_cnt_d;
  logic [1:0]      stb;

  state_t          state_q, state_d;
  logic [PW-1:0]   phase_q, phase_d;
  logic            s_q, s_d;
  logic            r_q, r_d;
  logic            q_expect_q, q_expect_d;
  logic [7:0]      conflict_cnt_q, conflict_cnt_d;

  // Synchronise both request lines and debounce them into stable levels.
  always_comb begin
    sync1_d   = {clr_req, set_req};
    sync2_d   = sync1_q;
    db_d      = db_q;
    db_prev_d = db_q;
    db_cnt_d  = '0;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] != db_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          db_d[i] = ~db_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 8'd1;
        end
      end
    end
  end

  // Single-cycle strobe on each debounced rising edge; falling edges are ignored.
  assign stb = db_q & ~db_prev_q;

  // Command FSM: chooses the pulse, times pulse and gap, tracks Q and conflicts.
  always_comb begin
    state_d        = state_q;
    phase_d        = phase_q;
    q_expect_d     = q_expect_q;
    conflict_cnt_d = conflict_cnt_q;
    unique case (state_q)
      IDLE: begin
        phase_d = '0;
        if (stb[0] && stb[1]) begin
          if (conflict_cnt_q != 8'hFF) begin
            conflict_cnt_d = conflict_cnt_q + 8'd1;
          end
          if (CLR_PRIORITY != 0) begin
            state_d    = DRIVE_R;
            q_expect_d = 1'b0;
          end
        end else if (stb[0]) begin
          state_d    = DRIVE_S;
          q_expect_d = 1'b1;
        end else if (stb[1]) begin
          state_d    = DRIVE_R;
          q_expect_d = 1'b0;
        end
      end
      DRIVE_S, DRIVE_R: begin
        if (phase_q == PULSE_LAST) begin
          phase_d = '0;
          state_d = (HOLDOFF == 0) ? IDLE : GAP;
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end
      GAP: begin
        if (phase_q == GAP_LAST) begin
          phase_d = '0;
          state_d = IDLE;
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        phase_d = '0;
      end
    endcase
    // S/R are registered copies of the next state so they leave flops glitch-free
    // and are mutually exclusive by construction.
    s_d = (state_d == DRIVE_S);
    r_d = (state_d == DRIVE_R);
  end

  // State registers; asynchronous reset clears everything, dropping S/R at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q        <= '0;
      sync2_q        <= '0;
      db_q           <= '0;
      db_prev_q      <= '0;
      db_cnt_q       <= '0;
      state_q        <= IDLE;
      phase_q        <= '0;
      s_q            <= 1'b0;
      r_q            <= 1'b0;
      q_expect_q     <= 1'b0;
      conflict_cnt_q <= '0;
    end else begin
      sync1_q        <= sync1_d;
      sync2_q        <= sync2_d;
      db_q           <= db_d;
      db_prev_q      <= db_prev_d;
      db_cnt_q       <= db_cnt_d;
      state_q        <= state_d;
      phase_q        <= phase_d;
      s_q            <= s_d;
      r_q            <= r_d;
      q_expect_q     <= q_expect_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  assign S            = s_q;
  assign R            = r_q;
  assign busy         = (state_q != IDLE);
  assign q_expect     = q_expect_q;
  assign conflict_cnt = conflict_cnt_q;

endmodule

// File: doc/sr_cmd_driver.md
Name: sr_cmd_driver

Overview:
- Upstream command stage for the SR flip-flop: converts raw, bouncy set/clear requests into clean, bounded-width S and R pulses.
- Guarantees the forbidden S=R=1 combination never reaches the flip-flop.
- Enforces a hold-off gap between commands and tracks the commanded Q state.
- Sits between push-button/external request lines and the SR stage's S/R inputs.

Parameters:
- DB_CYCLES, 4: consecutive stable synchronised samples required before a debounced level changes; range 1 to 255.
- PULSE_LEN, 2: cycles S or R is held high per command; range 1 to 255.
- HOLDOFF, 2: cycles S=R=0 enforced after each pulse before a new command is accepted; 0 allowed.
- CLR_PRIORITY, 1: on simultaneous set/clear strobes, 1 issues R and 0 issues nothing.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- set_req  in  1  raw asynchronous set request.
- clr_req  in  1  raw asynchronous clear request.
- S  out  1  registered set drive to the SR stage.
- R  out  1  registered reset drive to the SR stage.
- busy  out  1  high whenever the FSM is not IDLE.
- q_expect  out  1  Q value last commanded.
- conflict_cnt  out  8  saturating count of simultaneous set/clear strobes.

Behaviour:
- Interface (decided): one clock, clk; reset rst is asynchronous and active-high.
- Reset:
  - Async assertion immediately clears every register: synchronisers, debounced levels, debounce counters, FSM state (IDLE), S=0, R=0, busy=0, q_expect=0, conflict_cnt=0.
  - Reset mid-pulse drops S/R without waiting for a clock edge.
  - Operation resumes on the first clk edge after deassertion.
- Synchronisation: each request passes through a 2-flop synchroniser.
- Debounce (per input):
  - Counter increments while the synchronised value differs from the debounced level.
  - Counter clears to 0 whenever the two agree.
  - On reaching DB_CYCLES, the debounced level toggles and the counter clears.
- Strobe: a debounced 0->1 transition gives a 1-cycle strobe (set_stb / clr_stb). Falling edges produce nothing.
- Latency: with a request sampled high at edge 1 and held stable, S (or R) goes high after edge DB_CYCLES+3. With defaults, that is edge 7.
- FSM states: IDLE, DRIVE_S, DRIVE_R, GAP.
  - IDLE, set_stb only: go to DRIVE_S.
  - IDLE, clr_stb only: go to DRIVE_R.
  - IDLE, both strobes in the same cycle: conflict_cnt += 1 (saturating at 255). Then DRIVE_R if CLR_PRIORITY=1, otherwise stay IDLE.
  - DRIVE_S: S=1 and R=0 for exactly PULSE_LEN cycles. q_expect becomes 1 on the entry edge. Then go to GAP, or to IDLE if HOLDOFF=0.
  - DRIVE_R: same as DRIVE_S with R=1, S=0, q_expect becomes 0.
  - GAP: S=R=0 for exactly HOLDOFF cycles, then IDLE.
- Strobes arriving outside IDLE are discarded. There is no queue, and discards are not counted.
- Invariants:
  - S & R == 0 in every cycle.
  - S and R are driven directly from flops (glitch-free).
  - busy == (state != IDLE).
- A command that repeats the current q_expect is still issued as a full pulse; there is no suppression.
- Phase counter width: clog2 of max(PULSE_LEN, HOLDOFF), plus 1.

Test Plan:
- Defaults; release rst; set_req=1 from edge 1, held 20 cycles -> S=1 after edges 7..8 (2 cycles), R=0 throughout, busy=1 for 4 cycles, q_expect=1 from edge 7.
- set_req pulsed high for 3 cycles, then 0 -> no S or R pulse, busy stays 0, debounced level unchanged.
- set_req and clr_req rise on the same edge, CLR_PRIORITY=1 -> single R pulse of 2 cycles, S=0, conflict_cnt=1. Rerun with CLR_PRIORITY=0 -> no pulse, conflict_cnt=1.
- set command in progress; clr_req debounces high while busy -> clr strobe dropped, no R pulse after GAP, q_expect stays 1.
- rst asserted between clk edges during DRIVE_S -> S falls immediately. After release, busy=0, q_expect=0, conflict_cnt=0.
- 300 simultaneous-strobe events (requests toggled with enough spacing for debounce and GAP) -> conflict_cnt stops at 255. Assert S&R==0 across all tests.
